r_ptr_empty_ctrl: RTL and testbench
===================================

// Module: r_ptr_empty_ctrl
// PURPOSE
//  Read-side pointer and empty-flag controller of the asynchronous FIFO, the r_clk counterpart of the write-side controller.
//  Keeps the binary read pointer and drives r_addr to the dual-port memory.
//  Exports the Gray read pointer r_ptr for synchronisation into w_clk.
//  Synchronises the incoming Gray write pointer w_ptr into r_clk and generates a registered r_empty flag.
// PARAMETERS
//  ADDRESS_SIZE  4  memory address width; FIFO depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits
//  AE_THRESH     2  almost-empty threshold in entries (used only with R_ALMOST_EMPTY_EN)
// PORTS
//  r_clk           in   1                read-domain clock; the block's only clock
//  rrst            in   1                synchronous, active-high reset
//  r_en            in   1                read request
//  w_ptr           in   ADDRESS_SIZE+1   Gray write pointer from w_clk domain, asynchronous
//  r_ptr           out  ADDRESS_SIZE+1   Gray read pointer, registered
//  r_addr          out  ADDRESS_SIZE     memory read address = r_bin[ADDRESS_SIZE-1:0]
//  r_empty         out  1                FIFO empty, registered
//  r_almost_empty  out  1                only with R_ALMOST_EMPTY_EN
// BEHAVIOUR
//  - Reset and clock:
//    - One clock (r_clk). Reset rrst is synchronous and active-high.
//    - All flops reset synchronously: r_bin=0, r_ptr=0, both sync stages=0, r_empty=1, r_almost_empty=1.
//    - rrst overrides r_en on the same edge, including mid-operation.
//  - Pointer update:
//    - r_bnext = r_bin + (r_en & ~r_empty); a read while empty is ignored and does not advance.
//    - r_gnext = r_bnext ^ (r_bnext >> 1). On each edge: r_bin<=r_bnext, r_ptr<=r_gnext.
//    - Exactly one bit of r_ptr changes per accepted read.
//  - Wrap-around: ADDRESS_SIZE+1-bit arithmetic, modulo 2**(ADDRESS_SIZE+1); r_addr wraps 2**ADDRESS_SIZE-1 -> 0.
//  - Synchroniser: w_ptr passes through two r_clk flops (rq1_wptr, rq2_wptr), implemented locally with synchronous reset.
//  - Empty flag:
//    - r_empty <= (r_gnext == rq2_wptr). Full Gray compare, no MSB inversion.
//    - The flag asserts on the same edge as the read that consumes the last entry.
//  - Latency:
//    - A w_ptr change stable before edge k deasserts r_empty at edge k+2.
//    - One edge is the synchroniser; the other registers the flag.
//    - Memory data for r_addr is the RAM's concern; r_addr is valid while r_empty=0.
//  - Pessimism: r_empty may stay high up to 2 cycles longer than true occupancy; it never deasserts early.
// CONFIGURATION
//  - `define R_ALMOST_EMPTY_EN:
//    - Converts rq2_wptr to binary (rq2_wbin).
//    - count = rq2_wbin - r_bnext, mod 2**(ADDRESS_SIZE+1).
//    - r_almost_empty <= (count <= AE_THRESH), registered, same edge as r_empty.
//  - Without the macro: no r_almost_empty port, no converter, no extra logic.
// STRUCTURE
//  - Shared package: ptr_w = ADDRESS_SIZE+1 localparam, bin2gray function, gray2bin function.
//  - Sub-module gray_to_binary (param N):
//    - Purely combinational XOR-prefix.
//    - Instantiated only under R_ALMOST_EMPTY_EN.
//  - Registers (binary, Gray, sync, flags) are coded in-module with synchronous reset; async-reset flops are not used.
// TESTING (ADDRESS_SIZE=4, AE_THRESH=2)
//  1. rrst=1 for 2 edges, w_ptr=5'b00000 -> r_ptr=0, r_addr=0, r_empty=1, r_almost_empty=1.
//  2. w_ptr=0, r_en=1 for 5 edges -> r_addr stays 0, r_ptr stays 0, r_empty stays 1.
//  3. w_ptr -> 5'b00001 (gray 1) before edge k:
//     - r_empty=0 from edge k+2.
//     - One r_en pulse -> r_addr=1, r_ptr=5'b00001, r_empty=1 on that same edge.
//  4. w_ptr=5'b11000 (gray 16), r_en held 16 edges from 0:
//     - r_addr counts 0..15 -> 0.
//     - r_ptr ends 5'b11000; r_empty rises on the 16th read edge.
//  5. Three entries pending (w_ptr=gray 3), rrst=1 with r_en=1 on one edge -> r_ptr=0, r_bin=0, r_empty=1 after that edge.
//  6. With R_ALMOST_EMPTY_EN, w_ptr=5'b00010 (gray 3), r_ptr=0:
//     - r_almost_empty=0.
//     - One read (count 2) -> r_almost_empty=1 on that edge.

Source files
------------

// File: rtl/r_ptr_empty_ctrl_pkg.sv
// r_ptr_empty_ctrl_pkg
//   Shared definitions for the read-side FIFO pointer controller.
//   PTR_W is the pointer width of the default configuration (ADDRESS_SIZE+1).
//   bin2gray / gray2bin work on a 32-bit field. Narrower values are
//   zero-extended in and truncated back out by the caller.
package r_ptr_empty_ctrl_pkg;

    localparam int ADDR_SIZE_DEFAULT = 4;
    localparam int AE_THRESH_DEFAULT = 2;
    localparam int PTR_W             = ADDR_SIZE_DEFAULT + 1;
    localparam int FN_W              = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/r_ptr_empty_ctrl_gray_to_binary.sv
// gray_to_binary
//   Purely combinational Gray-to-binary converter (XOR prefix from the MSB).
//   Ports:
//     gray  in   N   Gray-coded value
//     bin   out  N   binary equivalent
module gray_to_binary #(
    parameter int N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    logic acc;

    always_comb begin
        bin      = '0;
        acc      = gray[N-1];
        bin[N-1] = acc;
        for (int i = N - 2; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/r_ptr_empty_ctrl.sv
// r_ptr_empty_ctrl
//   Read-side pointer and empty-flag controller of an asynchronous FIFO.
//   Holds the binary read pointer, drives the RAM read address, exports the
//   Gray read pointer for the write domain, synchronises the Gray write
//   pointer into r_clk and produces a registered empty flag.
//   Optional feature: define R_ALMOST_EMPTY_EN to add the r_almost_empty
//   output (occupancy <= AE_THRESH, measured against the synchronised write
//   pointer).
//   Ports:
//     r_clk           in   1                read clock
//     rrst            in   1                synchronous active-high reset
//     r_en            in   1                read request
//     w_ptr           in   ADDRESS_SIZE+1   Gray write pointer (async)
//     r_ptr           out  ADDRESS_SIZE+1   Gray read pointer, registered
//     r_addr          out  ADDRESS_SIZE     RAM read address
//     r_empty         out  1                FIFO empty, registered
//     r_almost_empty  out  1                R_ALMOST_EMPTY_EN only
module r_ptr_empty_ctrl
    import r_ptr_empty_ctrl_pkg::*;
#(
    parameter int ADDRESS_SIZE = ADDR_SIZE_DEFAULT,
    parameter int AE_THRESH    = AE_THRESH_DEFAULT
) (
    input  logic                    r_clk,
    input  logic                    rrst,
    input  logic                    r_en,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    r_empty
`ifdef R_ALMOST_EMPTY_EN
    ,
    output logic                    r_almost_empty
`endif
);

    localparam int PW = ADDRESS_SIZE + 1;

    logic [PW-1:0] r_bin_q, r_bin_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] rq1_wptr_q, rq1_wptr_d;
    logic [PW-1:0] rq2_wptr_q, rq2_wptr_d;
    logic          r_empty_q, r_empty_d;
    logic [PW-1:0] r_bnext;
    logic [PW-1:0] r_gnext;

    always_comb begin
        // A read while the (registered) flag says empty is dropped.
        r_bnext    = r_bin_q + {{(PW-1){1'b0}}, (r_en & ~r_empty_q)};
        r_gnext    = PW'(bin2gray(32'(r_bnext)));
        r_bin_d    = r_bnext;
        r_ptr_d    = r_gnext;
        rq1_wptr_d = w_ptr;
        rq2_wptr_d = rq1_wptr_q;
        // Both pointers carry the wrap bit, so equal Gray values mean empty.
        r_empty_d  = (r_gnext == rq2_wptr_q);
    end

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            r_bin_q    <= '0;
            r_ptr_q    <= '0;
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
            r_empty_q  <= 1'b1;
        end else begin
            r_bin_q    <= r_bin_d;
            r_ptr_q    <= r_ptr_d;
            rq1_wptr_q <= rq1_wptr_d;
            rq2_wptr_q <= rq2_wptr_d;
            r_empty_q  <= r_empty_d;
        end
    end

    assign r_ptr   = r_ptr_q;
    assign r_addr  = r_bin_q[ADDRESS_SIZE-1:0];
    assign r_empty = r_empty_q;

`ifdef R_ALMOST_EMPTY_EN
    logic [PW-1:0] rq2_wbin;
    logic [PW-1:0] r_count;
    logic [31:0]   r_count_ext;
    logic          r_almost_empty_q, r_almost_empty_d;

    gray_to_binary #(
        .N (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr_q),
        .bin  (rq2_wbin)
    );

    always_comb begin
        // Occupancy as seen after this edge's read; modulo pointer range.
        r_count          = rq2_wbin - r_bnext;
        r_count_ext      = 32'(r_count);
        r_almost_empty_d = (r_count_ext <= $unsigned(AE_THRESH));
    end

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            r_almost_empty_q <= 1'b1;
        end else begin
            r_almost_empty_q <= r_almost_empty_d;
        end
    end

    assign r_almost_empty = r_almost_empty_q;
`endif

endmodule

// File: tb/tb_r_ptr_empty_ctrl.sv
module tb_r_ptr_empty_ctrl;

    localparam int AW   = 4;
    localparam int PW   = AW + 1;
    localparam int MASK = (1 << PW) - 1;

    logic          r_clk = 1'b0;
    logic          rrst  = 1'b1;
    logic          r_en  = 1'b0;
    logic [PW-1:0] w_ptr = '0;
    logic [PW-1:0] r_ptr;
    logic [AW-1:0] r_addr;
    logic          r_empty;
    logic          r_almost_empty;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        logic [PW-1:0] ptr;
        logic [AW-1:0] addr;
        logic          empty;
        logic          aempty;
        int            acc;
    } exp_t;

    exp_t sb[$];

    // Reference model: read count, two-stage view of the write pointer,
    // occupancy derived in binary.
    int            m_rcnt;
    logic [PW-1:0] m_s1;
    logic [PW-1:0] m_s2;
    logic          m_empty;
    logic          m_aempty;

    r_ptr_empty_ctrl #(
        .ADDRESS_SIZE (AW),
        .AE_THRESH    (2)
    ) dut (
        .r_clk          (r_clk),
        .rrst           (rrst),
        .r_en           (r_en),
        .w_ptr          (w_ptr),
        .r_ptr          (r_ptr),
        .r_addr         (r_addr),
`ifdef R_ALMOST_EMPTY_EN
        .r_almost_empty (r_almost_empty),
`endif
        .r_empty        (r_empty)
    );

`ifndef R_ALMOST_EMPTY_EN
    assign r_almost_empty = 1'b0;
`endif

    always #5 r_clk = ~r_clk;

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        logic [PW-1:0] g;
        b = PW'(v & MASK);
        for (int i = 0; i < PW; i++) begin
            g[i] = (i == PW - 1) ? b[i] : (b[i] ^ b[i+1]);
        end
        return g;
    endfunction

    function automatic int from_gray(input logic [PW-1:0] g);
        int v;
        int bit_v;
        v     = 0;
        bit_v = 0;
        for (int i = PW - 1; i >= 0; i--) begin
            bit_v = bit_v ^ int'(g[i]);
            v     = v | (bit_v << i);
        end
        return v;
    endfunction

    task automatic model_edge(input string nm);
        exp_t e;
        int   acc;
        int   occ;
        if (rrst) begin
            m_rcnt   = 0;
            m_s1     = '0;
            m_s2     = '0;
            m_empty  = 1'b1;
            m_aempty = 1'b1;
            acc      = 0;
        end else begin
            acc      = (r_en && !m_empty) ? 1 : 0;
            m_rcnt   = (m_rcnt + acc) & MASK;
            occ      = (from_gray(m_s2) - m_rcnt) & MASK;
            m_empty  = (occ == 0);
            m_aempty = (occ <= 2);
            m_s2     = m_s1;
            m_s1     = w_ptr;
        end
        e.name   = nm;
        e.ptr    = to_gray(m_rcnt);
        e.addr   = AW'(m_rcnt);
        e.empty  = m_empty;
        e.aempty = m_aempty;
        e.acc    = acc;
        sb.push_back(e);
    endtask

    task automatic drive(input logic rs, input logic en, input logic [PW-1:0] wp,
                         input string nm);
        rrst  = rs;
        r_en  = en;
        w_ptr = wp;
        model_edge(nm);
        @(posedge r_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, "reset");
            e = sb.pop_front();
            checks++;
            if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
                failures++;
                $display("FAIL %s ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                         e.name, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
            end
`ifdef R_ALMOST_EMPTY_EN
            checks++;
            if (r_almost_empty !== e.aempty) begin
                failures++;
                $display("FAIL %s almost_empty actual=%b required=%b",
                         e.name, r_almost_empty, e.aempty);
            end
`endif
        end
    endtask

    task automatic test_read_when_empty();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, '0, "read_empty");
            e = sb.pop_front();
            checks++;
            if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
                failures++;
                $display("FAIL %s ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                         e.name, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
            end
        end
        checks++;
        if ({r_ptr, r_empty} !== {5'b00000, 1'b1}) begin
            failures++;
            $display("FAIL read_empty_final ptr/empty actual=%b/%b required=00000/1",
                     r_ptr, r_empty);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        logic seen_k1;
        logic seen_k2;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'b00001, "latency");
            e = sb.pop_front();
            if (i == 1) seen_k1 = r_empty;
            if (i == 2) seen_k2 = r_empty;
            checks++;
            if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
                failures++;
                $display("FAIL %s[%0d] ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                         e.name, i, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
            end
        end
        checks++;
        if ({seen_k1, seen_k2} !== 2'b10) begin
            failures++;
            $display("FAIL latency_edges empty@k+1/k+2 actual=%b/%b required=1/0",
                     seen_k1, seen_k2);
        end
        drive(1'b0, 1'b1, 5'b00001, "last_read");
        e = sb.pop_front();
        checks++;
        if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
            failures++;
            $display("FAIL %s ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                     e.name, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
        end
        checks++;
        if ({r_ptr, r_addr, r_empty} !== {5'b00001, 4'h1, 1'b1}) begin
            failures++;
            $display("FAIL last_read_const ptr/addr/empty actual=%b/%h/%b required=00001/1/1",
                     r_ptr, r_addr, r_empty);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        drive(1'b1, 1'b0, '0, "wrap_reset");
        void'(sb.pop_front());
        for (int i = 0; i < 19; i++) begin
            drive(1'b0, (i >= 3), 5'b11000, "wrap");
            e = sb.pop_front();
            checks++;
            if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
                failures++;
                $display("FAIL %s[%0d] ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                         e.name, i, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
            end
            if (i == 17) begin
                checks++;
                if ({r_addr, r_empty} !== {4'hf, 1'b0}) begin
                    failures++;
                    $display("FAIL wrap_15th addr/empty actual=%h/%b required=f/0",
                             r_addr, r_empty);
                end
            end
        end
        checks++;
        if ({r_ptr, r_addr, r_empty} !== {5'b11000, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL wrap_end ptr/addr/empty actual=%b/%h/%b required=11000/0/1",
                     r_ptr, r_addr, r_empty);
        end
    endtask

    task automatic test_reset_override();
        exp_t e;
        drive(1'b1, 1'b0, '0, "ovr_reset");
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 3), 5'b00110, "ovr_fill");
            e = sb.pop_front();
            checks++;
            if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
                failures++;
                $display("FAIL %s[%0d] ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                         e.name, i, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
            end
        end
        drive(1'b1, 1'b1, 5'b00110, "ovr_reset_read");
        e = sb.pop_front();
        checks++;
        if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
            failures++;
            $display("FAIL %s ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                     e.name, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
        end
        checks++;
        if ({r_ptr, r_addr, r_empty} !== {5'b00000, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL ovr_const ptr/addr/empty actual=%b/%h/%b required=00000/0/1",
                     r_ptr, r_addr, r_empty);
        end
    endtask

    task automatic test_almost_empty();
`ifdef R_ALMOST_EMPTY_EN
        exp_t e;
        drive(1'b1, 1'b0, '0, "ae_reset");
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 3), 5'b00010, "ae");
            e = sb.pop_front();
            checks++;
            if ({r_almost_empty, r_empty} !== {e.aempty, e.empty}) begin
                failures++;
                $display("FAIL %s[%0d] almost_empty/empty actual=%b/%b required=%b/%b",
                         e.name, i, r_almost_empty, r_empty, e.aempty, e.empty);
            end
            if (i == 2) begin
                checks++;
                if (r_almost_empty !== 1'b0) begin
                    failures++;
                    $display("FAIL ae_three actual=%b required=0", r_almost_empty);
                end
            end
        end
        checks++;
        if ({r_almost_empty, r_empty} !== 2'b10) begin
            failures++;
            $display("FAIL ae_two almost_empty/empty actual=%b/%b required=1/0",
                     r_almost_empty, r_empty);
        end
`endif
    endtask

    task automatic test_random();
        exp_t          e;
        int            w_cnt;
        logic [PW-1:0] prev_ptr;
        logic          en;
        drive(1'b1, 1'b0, '0, "rnd_reset");
        void'(sb.pop_front());
        w_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (i < 260 && $urandom_range(0, 1) == 1 && ((w_cnt - m_rcnt) & MASK) < 16)
                w_cnt = (w_cnt + 1) & MASK;
            en       = (i >= 260) ? 1'b1 : 1'($urandom_range(0, 1));
            prev_ptr = r_ptr;
            drive(1'b0, en, to_gray(w_cnt), "random");
            e = sb.pop_front();
            checks++;
            if ({r_ptr, r_addr, r_empty} !== {e.ptr, e.addr, e.empty}) begin
                failures++;
                $display("FAIL %s[%0d] ptr/addr/empty actual=%b/%h/%b required=%b/%h/%b",
                         e.name, i, r_ptr, r_addr, r_empty, e.ptr, e.addr, e.empty);
            end
            checks++;
            if ($countones(r_ptr ^ prev_ptr) != e.acc) begin
                failures++;
                $display("FAIL gray_step[%0d] bits_changed actual=%0d required=%0d",
                         i, $countones(r_ptr ^ prev_ptr), e.acc);
            end
`ifdef R_ALMOST_EMPTY_EN
            checks++;
            if (r_almost_empty !== e.aempty) begin
                failures++;
                $display("FAIL %s[%0d] almost_empty actual=%b required=%b",
                         e.name, i, r_almost_empty, e.aempty);
            end
`endif
        end
        checks++;
        if (r_empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty actual=%b required=1", r_empty);
        end
    endtask

    initial begin
        test_reset();
        test_read_when_empty();
        test_latency();
        test_wrap();
        test_reset_override();
        test_almost_empty();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
